// File: rtl/mips_core.sv
// Single-cycle MIPS-I integer core: program counter, decode, ALU and branch/jump
// resolution. The I-cache, D-cache and register file are external and answer
// combinationally within the cycle; the PC is the only architectural state held here.
module mips_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] iCacheReadData,
  output logic [31:0] iCacheReadAddr,
  input  logic [31:0] dCacheReadData,
  output logic [31:0] dCacheWriteData,
  output logic [31:0] dCacheAddr,
  output logic        dCacheWriteEn,
  output logic        dCacheReadEn,
  input  logic [31:0] rfReadData_p0,
  output logic [4:0]  rfReadAddr_p0,
  output logic        rfReadEn_p0,
  input  logic [31:0] rfReadData_p1,
  output logic [4:0]  rfReadAddr_p1,
  output logic        rfReadEn_p1,
  output logic [31:0] rfWriteData_p0,
  output logic [4:0]  rfWriteAddr_p0,
  output logic        rfWriteEn_p0
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // Set-less-than helpers produce the architectural 0/1 word.
  function automatic logic [31:0] slt_signed(input logic signed [31:0] a,
                                             input logic signed [31:0] b);
    return {31'b0, (a < b)};
  endfunction

  function automatic logic [31:0] slt_unsigned(input logic [31:0] a, input logic [31:0] b);
    return {31'b0, (a < b)};
  endfunction

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4;
  logic [31:0] instr;
  logic [5:0]  op, funct;
  logic [4:0]  rs_a, rt_a, rd_a, shamt;
  logic signed [31:0] rs_v, rt_v, imm_sext;
  logic [31:0] imm_zext, br_target, j_target;

  // decoded controls and results, before the reset gate
  logic        wr_req, re0, re1, mem_rd, mem_wr, br_taken, do_jump, do_jr;
  logic [4:0]  dest;
  logic [31:0] result;

  assign instr     = iCacheReadData;
  assign op        = instr[31:26];
  assign rs_a      = instr[25:21];
  assign rt_a      = instr[20:16];
  assign rd_a      = instr[15:11];
  assign shamt     = instr[10:6];
  assign funct     = instr[5:0];
  assign rs_v      = rfReadData_p0;
  assign rt_v      = rfReadData_p1;
  assign imm_sext  = {{16{instr[15]}}, instr[15:0]};
  assign imm_zext  = {16'h0000, instr[15:0]};
  assign pc_plus4  = pc_q + 32'd4;
  assign br_target = pc_plus4 + {imm_sext[29:0], 2'b00};
  assign j_target  = {pc_plus4[31:28], instr[25:0], 2'b00};

  // Instruction decode and ALU: one result, one destination, source-use flags.
  always_comb begin
    wr_req   = 1'b0;
    re0      = 1'b0;
    re1      = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    br_taken = 1'b0;
    do_jump  = 1'b0;
    do_jr    = 1'b0;
    dest     = 5'd0;
    result   = 32'h0;
    unique case (op)
      OP_RTYPE: begin
        dest = rd_a;
        unique case (funct)
          FN_ADD, FN_ADDU: begin wr_req = 1'b1; re0 = 1'b1; re1 = 1'b1; result = rs_v + rt_v; end
          FN_SUB, FN_SUBU: begin wr_req = 1'b1; re0 = 1'b1; re1 = 1'b1; result = rs_v - rt_v; end
          FN_AND:  begin wr_req = 1'b1; re0 = 1'b1; re1 = 1'b1; result = rs_v & rt_v; end
          FN_OR:   begin wr_req = 1'b1; re0 = 1'b1; re1 = 1'b1; result = rs_v | rt_v; end
          FN_XOR:  begin wr_req = 1'b1; re0 = 1'b1; re1 = 1'b1; result = rs_v ^ rt_v; end
          FN_NOR:  begin wr_req = 1'b1; re0 = 1'b1; re1 = 1'b1; result = ~(rs_v | rt_v); end
          FN_SLT:  begin wr_req = 1'b1; re0 = 1'b1; re1 = 1'b1; result = slt_signed(rs_v, rt_v); end
          FN_SLTU: begin wr_req = 1'b1; re0 = 1'b1; re1 = 1'b1; result = slt_unsigned(rs_v, rt_v); end
          FN_SLL:  begin wr_req = 1'b1; re1 = 1'b1; result = rt_v << shamt; end
          FN_SRL:  begin wr_req = 1'b1; re1 = 1'b1; result = rt_v >> shamt; end
          FN_SRA:  begin wr_req = 1'b1; re1 = 1'b1; result = rt_v >>> shamt; end
          FN_JR:   begin re0 = 1'b1; do_jr = 1'b1; dest = 5'd0; end
          default: dest = 5'd0;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin wr_req = 1'b1; re0 = 1'b1; dest = rt_a; result = rs_v + imm_sext; end
      OP_SLTI:  begin wr_req = 1'b1; re0 = 1'b1; dest = rt_a; result = slt_signed(rs_v, imm_sext); end
      OP_SLTIU: begin wr_req = 1'b1; re0 = 1'b1; dest = rt_a; result = slt_unsigned(rs_v, imm_sext); end
      OP_ANDI:  begin wr_req = 1'b1; re0 = 1'b1; dest = rt_a; result = rs_v & imm_zext; end
      OP_ORI:   begin wr_req = 1'b1; re0 = 1'b1; dest = rt_a; result = rs_v | imm_zext; end
      OP_XORI:  begin wr_req = 1'b1; re0 = 1'b1; dest = rt_a; result = rs_v ^ imm_zext; end
      OP_LUI:   begin wr_req = 1'b1; dest = rt_a; result = {instr[15:0], 16'h0000}; end
      OP_LW:    begin wr_req = 1'b1; re0 = 1'b1; mem_rd = 1'b1; dest = rt_a; result = dCacheReadData; end
      OP_SW:    begin re0 = 1'b1; re1 = 1'b1; mem_wr = 1'b1; end
      OP_BEQ:   begin re0 = 1'b1; re1 = 1'b1; br_taken = (rs_v == rt_v); end
      OP_BNE:   begin re0 = 1'b1; re1 = 1'b1; br_taken = (rs_v != rt_v); end
      OP_J:     do_jump = 1'b1;
      OP_JAL:   begin do_jump = 1'b1; wr_req = 1'b1; dest = 5'd31; result = pc_plus4; end
      default:  ;
    endcase
  end

  // Next-PC selection; jumps and branches resolve in the same cycle (no delay slot).
  always_comb begin
    pc_d = pc_plus4;
    if (do_jr)         pc_d = rs_v;
    else if (do_jump)  pc_d = j_target;
    else if (br_taken) pc_d = br_target;
  end

  // Port drive: everything is quiet while reset is held; writes to $0 are suppressed.
  always_comb begin
    iCacheReadAddr  = pc_q;
    rfReadAddr_p0   = 5'd0;
    rfReadAddr_p1   = 5'd0;
    rfReadEn_p0     = 1'b0;
    rfReadEn_p1     = 1'b0;
    rfWriteAddr_p0  = 5'd0;
    rfWriteData_p0  = 32'h0;
    rfWriteEn_p0    = 1'b0;
    dCacheAddr      = 32'h0;
    dCacheWriteData = 32'h0;
    dCacheWriteEn   = 1'b0;
    dCacheReadEn    = 1'b0;
    if (rst) begin
      rfReadAddr_p0   = rs_a;
      rfReadAddr_p1   = rt_a;
      rfReadEn_p0     = re0;
      rfReadEn_p1     = re1;
      rfWriteAddr_p0  = dest;
      rfWriteData_p0  = wr_req ? result : 32'h0;
      rfWriteEn_p0    = wr_req && (dest != 5'd0);
      dCacheAddr      = (mem_rd || mem_wr) ? (rs_v + imm_sext) : 32'h0;
      dCacheWriteData = mem_wr ? rt_v : 32'h0;
      dCacheWriteEn   = mem_wr;
      dCacheReadEn    = mem_rd;
    end
  end

  // Program counter: the only state; retires one instruction per rising edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc_q <= RESET_PC;
    else      pc_q <= pc_d;
  end

endmodule

// File: tb/tb_mips_core.sv
// Directed bench for mips_core: a table of single-instruction decode/ALU vectors
// followed by hand-written PC sequences for reset, branches, jumps and wrap-around.
module tb_mips_core;

  logic        clk;
  logic        rst;
  logic [31:0] iCacheReadData, iCacheReadAddr;
  logic [31:0] dCacheReadData, dCacheWriteData, dCacheAddr;
  logic        dCacheWriteEn, dCacheReadEn;
  logic [31:0] rfReadData_p0, rfReadData_p1, rfWriteData_p0;
  logic [4:0]  rfReadAddr_p0, rfReadAddr_p1, rfWriteAddr_p0;
  logic        rfReadEn_p0, rfReadEn_p1, rfWriteEn_p0;

  int passed = 0;
  int total  = 0;

  mips_core #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .iCacheReadData(iCacheReadData), .iCacheReadAddr(iCacheReadAddr),
    .dCacheReadData(dCacheReadData), .dCacheWriteData(dCacheWriteData),
    .dCacheAddr(dCacheAddr), .dCacheWriteEn(dCacheWriteEn), .dCacheReadEn(dCacheReadEn),
    .rfReadData_p0(rfReadData_p0), .rfReadAddr_p0(rfReadAddr_p0), .rfReadEn_p0(rfReadEn_p0),
    .rfReadData_p1(rfReadData_p1), .rfReadAddr_p1(rfReadAddr_p1), .rfReadEn_p1(rfReadEn_p1),
    .rfWriteData_p0(rfWriteData_p0), .rfWriteAddr_p0(rfWriteAddr_p0), .rfWriteEn_p0(rfWriteEn_p0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] dmem;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        re0;
    logic        re1;
    logic        dwe;
    logic        dre;
    logic [31:0] daddr;
    logic [31:0] dwd;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  task automatic add(input logic [31:0] instr, rs, rt, dmem, input logic we,
                     input logic [4:0] wa, input logic [31:0] wd, input logic re0, re1,
                     dwe, dre, input logic [31:0] daddr, dwd);
    vq.push_back('{instr, rs, rt, dmem, we, wa, wd, re0, re1, dwe, dre, daddr, dwd});
  endtask

  // Drive one instruction at the falling edge, let it retire, sample after the edge.
  task automatic step(input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt);
    @(negedge clk);
    iCacheReadData = instr;
    rfReadData_p0  = rs;
    rfReadData_p1  = rt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //   instr         rs            rt            dmem          we wa     wd            re0 re1 dwe dre daddr        dwd
    add(32'h014B4820, 32'h5,        32'h3,        32'h0,        1, 5'd9,  32'h8,        1, 1, 0, 0, 32'h0,       32'h0);
    add(32'h014B4824, 32'hF0F0,     32'hFF00,     32'h0,        1, 5'd9,  32'hF000,     1, 1, 0, 0, 32'h0,       32'h0);
    add(32'h014B4825, 32'hF0F0,     32'hFF00,     32'h0,        1, 5'd9,  32'hFFF0,     1, 1, 0, 0, 32'h0,       32'h0);
    add(32'h014B4822, 32'h3,        32'h5,        32'h0,        1, 5'd9,  32'hFFFFFFFE, 1, 1, 0, 0, 32'h0,       32'h0);
    add(32'h014B4826, 32'hF0F0,     32'hFF00,     32'h0,        1, 5'd9,  32'h0FF0,     1, 1, 0, 0, 32'h0,       32'h0);
    add(32'h014B4827, 32'hF0F0,     32'hFF00,     32'h0,        1, 5'd9,  32'hFFFF000F, 1, 1, 0, 0, 32'h0,       32'h0);
    add(32'h014B482A, 32'hFFFFFFFF, 32'h1,        32'h0,        1, 5'd9,  32'h1,        1, 1, 0, 0, 32'h0,       32'h0);
    add(32'h014B482B, 32'hFFFFFFFF, 32'h1,        32'h0,        1, 5'd9,  32'h0,        1, 1, 0, 0, 32'h0,       32'h0);
    add(32'h000B4900, 32'h0,        32'h81,       32'h0,        1, 5'd9,  32'h810,      0, 1, 0, 0, 32'h0,       32'h0);
    add(32'h000B4903, 32'h0,        32'h80000000, 32'h0,        1, 5'd9,  32'hF8000000, 0, 1, 0, 0, 32'h0,       32'h0);
    add(32'h000B4902, 32'h0,        32'h80000000, 32'h0,        1, 5'd9,  32'h08000000, 0, 1, 0, 0, 32'h0,       32'h0);
    add(32'h20200005, 32'hA,        32'h0,        32'h0,        0, 5'd0,  32'h0,        1, 0, 0, 0, 32'h0,       32'h0);
    add(32'h2422FFFF, 32'h0,        32'h0,        32'h0,        1, 5'd2,  32'hFFFFFFFF, 1, 0, 0, 0, 32'h0,       32'h0);
    add(32'h3022FFFF, 32'h12345678, 32'h0,        32'h0,        1, 5'd2,  32'h5678,     1, 0, 0, 0, 32'h0,       32'h0);
    add(32'h3C021234, 32'h0,        32'h0,        32'h0,        1, 5'd2,  32'h12340000, 0, 0, 0, 0, 32'h0,       32'h0);
    add(32'h28220001, 32'hFFFFFFFF, 32'h0,        32'h0,        1, 5'd2,  32'h1,        1, 0, 0, 0, 32'h0,       32'h0);
    add(32'h2C220001, 32'hFFFFFFFF, 32'h0,        32'h0,        1, 5'd2,  32'h0,        1, 0, 0, 0, 32'h0,       32'h0);
    add(32'h8C22FFFC, 32'h100,      32'h0,        32'hDEADBEEF, 1, 5'd2,  32'hDEADBEEF, 1, 0, 0, 1, 32'hFC,      32'h0);
    add(32'hAC220008, 32'h100,      32'h55,       32'h0,        0, 5'd0,  32'h0,        1, 1, 1, 0, 32'h108,     32'h55);
    add(32'hFC000000, 32'h1,        32'h2,        32'h0,        0, 5'd0,  32'h0,        0, 0, 0, 0, 32'h0,       32'h0);
    add(32'h014B483F, 32'h1,        32'h2,        32'h0,        0, 5'd0,  32'h0,        0, 0, 0, 0, 32'h0,       32'h0);
    add(32'h3822FFFF, 32'hF0F0,     32'h0,        32'h0,        1, 5'd2,  32'h0F0F,     1, 0, 0, 0, 32'h0,       32'h0);
    add(32'h3422000F, 32'hF0,       32'h0,        32'h0,        1, 5'd2,  32'hFF,       1, 0, 0, 0, 32'h0,       32'h0);
    add(32'h00200008, 32'h0,        32'h0,        32'h0,        0, 5'd0,  32'h0,        1, 0, 0, 0, 32'h0,       32'h0);

    rst = 1'b0;
    iCacheReadData = 32'h014B4820;
    rfReadData_p0 = 32'h5;
    rfReadData_p1 = 32'h3;
    dCacheReadData = 32'h0;

    // Reset holds everything quiet regardless of the instruction presented.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pc", iCacheReadAddr, 32'h0);
    chk("reset_en", {27'b0, rfWriteEn_p0, rfReadEn_p0, rfReadEn_p1, dCacheWriteEn, dCacheReadEn}, 32'h0);
    chk("reset_wd", rfWriteData_p0, 32'h0);

    // Release: PC advances 0,4,8.
    @(negedge clk);
    iCacheReadData = 32'h0;
    rst = 1'b1;
    #1 chk("pc0", iCacheReadAddr, 32'h0);
    @(posedge clk); #1 chk("pc4", iCacheReadAddr, 32'h4);
    @(posedge clk); #1 chk("pc8", iCacheReadAddr, 32'h8);

    // ADD register addresses.
    @(negedge clk);
    iCacheReadData = 32'h014B4820;
    rfReadData_p0 = 32'h5;
    rfReadData_p1 = 32'h3;
    #1;
    chk("add_ra0", {27'b0, rfReadAddr_p0}, 32'd10);
    chk("add_ra1", {27'b0, rfReadAddr_p1}, 32'd11);

    // Table-driven decode/ALU vectors.
    foreach (vq[i]) begin
      @(negedge clk);
      iCacheReadData = vq[i].instr;
      rfReadData_p0  = vq[i].rs;
      rfReadData_p1  = vq[i].rt;
      dCacheReadData = vq[i].dmem;
      #1;
      chk($sformatf("v%0d_ctl", i),
          {27'b0, rfWriteEn_p0, rfReadEn_p0, rfReadEn_p1, dCacheWriteEn, dCacheReadEn},
          {27'b0, vq[i].we, vq[i].re0, vq[i].re1, vq[i].dwe, vq[i].dre});
      chk($sformatf("v%0d_daddr", i), dCacheAddr, vq[i].daddr);
      chk($sformatf("v%0d_dwd", i), dCacheWriteData, vq[i].dwd);
      if (vq[i].we) begin
        chk($sformatf("v%0d_wa", i), {27'b0, rfWriteAddr_p0}, {27'b0, vq[i].wa});
        chk($sformatf("v%0d_wd", i), rfWriteData_p0, vq[i].wd);
      end
    end

    // Asynchronous reset: PC returns to 0 without a clock edge.
    @(negedge clk);
    iCacheReadData = 32'h0;
    #2 rst = 1'b0;
    #1 chk("async_pc", iCacheReadAddr, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Walk NOPs up to PC 0x20.
    repeat (8) @(posedge clk);
    #1 chk("pc20", iCacheReadAddr, 32'h20);

    step(32'h10220003, 32'h7, 32'h7);
    chk("beq_taken", iCacheReadAddr, 32'h30);
    step(32'h14220003, 32'h7, 32'h7);
    chk("bne_eq", iCacheReadAddr, 32'h34);
    step(32'h08000010, 32'h0, 32'h0);
    chk("j", iCacheReadAddr, 32'h40);

    // JAL: link value before the edge, target after.
    @(negedge clk);
    iCacheReadData = 32'h0C000004;
    #1;
    chk("jal_we", {31'b0, rfWriteEn_p0}, 32'h1);
    chk("jal_wa", {27'b0, rfWriteAddr_p0}, 32'd31);
    chk("jal_wd", rfWriteData_p0, 32'h44);
    @(posedge clk); #1 chk("jal_pc", iCacheReadAddr, 32'h10);

    step(32'h00200008, 32'h80, 32'h0);
    chk("jr", iCacheReadAddr, 32'h80);
    step(32'h1422FFFE, 32'h1, 32'h2);
    chk("bne_back", iCacheReadAddr, 32'h7C);
    step(32'h10220005, 32'h1, 32'h2);
    chk("beq_not", iCacheReadAddr, 32'h80);

    // PC wrap from the top of the address space.
    step(32'h00200008, 32'hFFFFFFFC, 32'h0);
    chk("pc_top", iCacheReadAddr, 32'hFFFFFFFC);
    step(32'h0, 32'h0, 32'h0);
    chk("pc_wrap", iCacheReadAddr, 32'h0);

    // Reset dropping mid-instruction abandons the write.
    @(negedge clk);
    iCacheReadData = 32'h014B4820;
    rfReadData_p0 = 32'h5;
    rfReadData_p1 = 32'h3;
    #1 chk("mid_we_on", {31'b0, rfWriteEn_p0}, 32'h1);
    #1 rst = 1'b0;
    #1 chk("mid_we_off", {31'b0, rfWriteEn_p0}, 32'h0);
    chk("mid_pc", iCacheReadAddr, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
